// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the core-side memory port arbiter.
// Holds the arbiter state encoding, the 2:1 memory-path mux select values,
// default bus widths, and the width of the IF starvation counter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_LSU = 2'd2
  } arb_state_t;

  localparam logic MUX_SEL_IF  = 1'b0;
  localparam logic MUX_SEL_LSU = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Wide enough for the largest supported MAX_WAIT (15).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/arb_prio_starve.sv
// Purpose: LSU-first priority pick between IF and LSU with an IF starvation guard.
// Latency: grant is combinational from the requests; wait_cnt updates on the grant edge.
// Backpressure: no grant is produced while i_en is low (arbiter busy).
// Ports: i_en (arbiter idle), i_if_req / i_lsu_req (requests),
//        o_gnt_if / o_gnt_lsu (one-hot grant strobe), o_wait_cnt (LSU wins while IF waited).
module arb_prio_starve
  import cpu_mem_pkg::*;
#(
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_if_req,
  input  logic              i_lsu_req,
  output logic              o_gnt_if,
  output logic              o_gnt_lsu,
  output logic [WAIT_W-1:0] o_wait_cnt
);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_starved;

  assign w_starved = (r_wait_cnt == WAIT_W'(MAX_WAIT));

  // LSU wins unless IF is also asking and has already been passed over MAX_WAIT times.
  always_comb begin
    o_gnt_lsu = 1'b0;
    o_gnt_if  = 1'b0;
    if (i_en) begin
      o_gnt_lsu = i_lsu_req && !(i_if_req && w_starved);
      o_gnt_if  = i_if_req && !o_gnt_lsu;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (o_gnt_if) begin
      r_wait_cnt <= '0;
    end else if (o_gnt_lsu && i_if_req && !w_starved) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  assign o_wait_cnt = r_wait_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and the LSU.
// Latency: request in IDLE at N -> gnt/mem_req at N+1; mem_ack at M -> rvalid at M+1.
// Backpressure: one transaction in flight; requesters hold req+payload until gnt,
//               the memory holds off by withholding mem_ack (payload stays frozen).
// Ports: if_* (fetch side), lsu_* (load/store side), mem_* (registered memory request
//        and response), mux_sel (memory path select, 0 = IF, 1 = LSU).
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mux_sel
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_idle;
  logic              w_gnt_if;
  logic              w_gnt_lsu;
  logic              w_done_if;
  logic              w_done_lsu;
  logic [WAIT_W-1:0] w_wait_cnt;

  logic              r_if_gnt;
  logic              r_lsu_gnt;
  logic              r_if_rvalid;
  logic              r_lsu_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_lsu_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;
  logic              r_mux_sel;

  assign w_idle = (r_state == ST_IDLE);

  arb_prio_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_idle),
    .i_if_req   (if_req),
    .i_lsu_req  (lsu_req),
    .o_gnt_if   (w_gnt_if),
    .o_gnt_lsu  (w_gnt_lsu),
    .o_wait_cnt (w_wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus the per-owner completion strobes; mem_ack outside BUSY is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_done_if   = 1'b0;
    w_done_lsu  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_lsu)     w_state_nxt = ST_BUSY_LSU;
        else if (w_gnt_if) w_state_nxt = ST_BUSY_IF;
      end
      ST_BUSY_IF: begin
        if (mem_ack) begin
          w_state_nxt = ST_IDLE;
          w_done_if   = 1'b1;
        end
      end
      ST_BUSY_LSU: begin
        if (mem_ack) begin
          w_state_nxt = ST_IDLE;
          w_done_lsu  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Payload is captured only on a grant edge, so it stays frozen for the whole busy
  // period regardless of what the requesters do meanwhile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_gnt     <= 1'b0;
      r_lsu_gnt    <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_if_rdata   <= '0;
      r_lsu_rdata  <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
      r_mux_sel    <= 1'b0;
    end else begin
      r_if_gnt     <= w_gnt_if;
      r_lsu_gnt    <= w_gnt_lsu;
      r_if_rvalid  <= w_done_if;
      r_lsu_rvalid <= w_done_lsu;
      if (w_done_if)  r_if_rdata  <= mem_rdata;
      if (w_done_lsu) r_lsu_rdata <= mem_rdata;

      if (w_gnt_lsu) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= lsu_we;
        r_mem_addr  <= lsu_addr;
        r_mem_wdata <= lsu_wdata;
        r_mem_be    <= lsu_be;
        r_mux_sel   <= MUX_SEL_LSU;
      end else if (w_gnt_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= '1;
        r_mux_sel   <= MUX_SEL_IF;
      end else if (w_done_if || w_done_lsu) begin
        r_mem_req   <= 1'b0;
      end
    end
  end

  assign if_gnt     = r_if_gnt;
  assign lsu_gnt    = r_lsu_gnt;
  assign if_rvalid  = r_if_rvalid;
  assign lsu_rvalid = r_lsu_rvalid;
  assign if_rdata   = r_if_rdata;
  assign lsu_rdata  = r_lsu_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign mux_sel    = r_mux_sel;

endmodule
